// File: rtl/dcache_writeback_unit_pkg.sv
// Shared D-cache writeback configuration: line geometry, FSM states and the
// release-buffer entry layout.
package dcache_pkg;

  localparam int unsigned LINE_BEATS = 16;
  localparam int unsigned IDX_BITS   = 6;
  localparam int unsigned BEAT_BITS  = $clog2(LINE_BEATS);
  localparam int unsigned ADDR_BITS  = IDX_BITS + BEAT_BITS + 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } wb_state_e;

  typedef logic [BEAT_BITS-1:0] beat_t;

  typedef struct packed {
    beat_t       beat;
    logic [31:0] data;
  } release_beat_t;

  localparam beat_t LAST_BEAT = beat_t'(LINE_BEATS - 1);

endpackage

// File: rtl/dcache_writeback_unit_if.sv
// Writeback unit bus bundle: command, data-array request/response and release
// stream. The writeback unit uses the master view.
interface dcache_writeback_unit_if;
  import dcache_pkg::*;

  logic                 io_req_valid;
  logic                 io_req_ready;
  logic [IDX_BITS-1:0]  io_req_bits_idx;
  logic [3:0]           io_req_bits_way_en;

  logic                 io_data_req_valid;
  logic                 io_data_req_ready;
  logic [ADDR_BITS-1:0] io_data_req_bits_addr;
  logic                 io_data_req_bits_write;
  logic [31:0]          io_data_req_bits_wdata;
  logic [3:0]           io_data_req_bits_eccMask;
  logic [3:0]           io_data_req_bits_way_en;

  logic [31:0]          io_data_resp_0;
  logic [31:0]          io_data_resp_1;
  logic [31:0]          io_data_resp_2;
  logic [31:0]          io_data_resp_3;

  logic                 io_release_valid;
  logic                 io_release_ready;
  logic [31:0]          io_release_bits_data;
  logic [BEAT_BITS-1:0] io_release_bits_beat;
  logic                 io_release_bits_last;

  logic                 io_busy;

  modport master (
    input  io_req_valid, io_req_bits_idx, io_req_bits_way_en,
    input  io_data_req_ready,
    input  io_data_resp_0, io_data_resp_1, io_data_resp_2, io_data_resp_3,
    input  io_release_ready,
    output io_req_ready,
    output io_data_req_valid, io_data_req_bits_addr, io_data_req_bits_write,
    output io_data_req_bits_wdata, io_data_req_bits_eccMask, io_data_req_bits_way_en,
    output io_release_valid, io_release_bits_data, io_release_bits_beat,
    output io_release_bits_last,
    output io_busy
  );

  modport slave (
    output io_req_valid, io_req_bits_idx, io_req_bits_way_en,
    output io_data_req_ready,
    output io_data_resp_0, io_data_resp_1, io_data_resp_2, io_data_resp_3,
    output io_release_ready,
    input  io_req_ready,
    input  io_data_req_valid, io_data_req_bits_addr, io_data_req_bits_write,
    input  io_data_req_bits_wdata, io_data_req_bits_eccMask, io_data_req_bits_way_en,
    input  io_release_valid, io_release_bits_data, io_release_bits_beat,
    input  io_release_bits_last,
    input  io_busy
  );

endinterface

// File: rtl/dcache_writeback_unit_release_buffer.sv
// Two-entry FIFO holding {beat, data} between the data-array response and the
// release port.
module release_buffer
  import dcache_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  release_beat_t push_data,
  input  logic          pop,
  output release_beat_t head,
  output logic [1:0]    count
);

  release_beat_t mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // The upstream credit rule keeps pushes from ever landing on a full buffer.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && (count == 2'd2) && !pop));

endmodule

// File: rtl/dcache_writeback_unit.sv
// Victim-line writeback: reads one line from the D-cache data array beat by
// beat and streams it in order on the release port.
module dcache_writeback_unit
  import dcache_pkg::*;
(
  input logic                     clock,
  input logic                     reset,
  dcache_writeback_unit_if.master wb
);

  wb_state_e           state;
  logic [IDX_BITS-1:0] idx_q;
  logic [3:0]          way_q;
  beat_t               rd_cnt;
  beat_t               tx_cnt;
  beat_t               inflight_beat;
  logic                inflight;

  logic                accept;
  logic                grant;
  logic                pop;
  logic [2:0]          avail;
  logic [31:0]         resp [4];
  logic [31:0]         sel_word;
  release_beat_t       push_data;
  release_beat_t       head;
  logic [1:0]          buf_count;

  assign resp[0] = wb.io_data_resp_0;
  assign resp[1] = wb.io_data_resp_1;
  assign resp[2] = wb.io_data_resp_2;
  assign resp[3] = wb.io_data_resp_3;

  always_comb begin
    sel_word = '0;
    for (int unsigned w = 0; w < 4; w++) begin
      if (way_q[w]) sel_word = sel_word | resp[w];
    end
  end

  // Credits cover both buffered beats and the read whose data lands next cycle.
  assign avail = 3'(buf_count) + 3'(inflight) - 3'(pop);

  assign wb.io_req_ready             = !reset && (state == IDLE);
  assign wb.io_data_req_valid        = !reset && (state == READ) && (avail < 3'd2);
  assign wb.io_data_req_bits_addr    = {idx_q, rd_cnt, 2'b00};
  assign wb.io_data_req_bits_write   = 1'b0;
  assign wb.io_data_req_bits_wdata   = '0;
  assign wb.io_data_req_bits_eccMask = '0;
  assign wb.io_data_req_bits_way_en  = way_q;

  assign wb.io_release_valid     = !reset && (buf_count != 2'd0);
  assign wb.io_release_bits_data = head.data;
  assign wb.io_release_bits_beat = head.beat;
  assign wb.io_release_bits_last = (head.beat == LAST_BEAT);
  assign wb.io_busy              = (state != IDLE);

  assign accept = wb.io_req_valid && wb.io_req_ready;
  assign grant  = wb.io_data_req_valid && wb.io_data_req_ready;
  assign pop    = wb.io_release_valid && wb.io_release_ready;

  assign push_data = '{beat: inflight_beat, data: sel_word};

  release_buffer u_release_buffer (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (buf_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      idx_q         <= '0;
      way_q         <= '0;
      rd_cnt        <= '0;
      tx_cnt        <= '0;
      inflight_beat <= '0;
      inflight      <= 1'b0;
    end else begin
      inflight <= grant;
      if (grant) begin
        inflight_beat <= rd_cnt;
        rd_cnt        <= rd_cnt + 1'b1;
      end
      if (pop) tx_cnt <= tx_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (accept) begin
            idx_q  <= wb.io_req_bits_idx;
            way_q  <= wb.io_req_bits_way_en;
            rd_cnt <= '0;
            tx_cnt <= '0;
            state  <= READ;
          end
        end
        READ: begin
          if (grant && (rd_cnt == LAST_BEAT)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (head.beat == LAST_BEAT)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_in_order: assert property (@(posedge clock) disable iff (reset)
    pop |-> (head.beat == tx_cnt));

endmodule

// File: doc/dcache_writeback_unit.md
# dcache_writeback_unit

Reads one victim cache line out of the D-cache data array, beat by beat, and streams it to the release/probe path as 32-bit beats with valid/ready flow control. It sits directly upstream of the data array, issuing read requests on the data-array request port through the D-cache arbiter. It also consumes the four per-way read words the data array returns one cycle later.

## Interface
- `LINE_BEATS`, 16: 32-bit beats per line; power of two.
- `IDX_BITS`, 6: set-index width; `IDX_BITS + log2(LINE_BEATS) + 2 = 12`.
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `io_req_valid` in 1, `io_req_ready` out 1: writeback command handshake.
- `io_req_bits_idx` in IDX_BITS: victim set index.
- `io_req_bits_way_en` in 4: victim way, one-hot.
- `io_data_req_valid` out 1, `io_data_req_ready` in 1: read request to the data array; `io_data_req_ready` is the arbiter grant.
- `io_data_req_bits_addr` out 12: `{idx, beat, 2'b00}`.
- `io_data_req_bits_write` out 1: constant 0.
- `io_data_req_bits_wdata` out 32: constant 0.
- `io_data_req_bits_eccMask` out 4: constant 0.
- `io_data_req_bits_way_en` out 4: registered victim way.
- `io_data_resp_0..3` in 32 each: data-array read words, valid the cycle after a granted read.
- `io_release_valid` out 1, `io_release_ready` in 1: outgoing beat handshake.
- `io_release_bits_data` out 32, `io_release_bits_beat` out log2(LINE_BEATS), `io_release_bits_last` out 1: beat payload.
- `io_busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, READ, DRAIN.
- **IDLE**
  - `io_req_ready = !reset`.
  - On accept, capture idx and way_en, clear `rd_cnt` and `tx_cnt`, and go to READ.
- **READ**
  - `io_data_req_valid = (credits − pop) < 2`.
  - `credits` = buffer entries + (granted read in the previous cycle).
  - `pop` = `io_release_valid & io_release_ready` this cycle.
  - A granted read (`valid & ready`) increments `rd_cnt`.
  - The grant for beat `LINE_BEATS−1` moves the FSM to DRAIN.
  - No grant means no read in flight: the next cycle captures nothing, and the same beat is re-requested.
- **Response path**
  - In the cycle after a grant, select `io_data_resp_w` with the registered one-hot way (AND-OR mux).
  - Push the selected word into a 2-entry FIFO, tagged with its beat number.
- **Release path**
  - Head of FIFO drives the release outputs.
  - `last = (beat == LINE_BEATS−1)`.
  - Each pop increments `tx_cnt`.
- **DRAIN**
  - No further reads.
  - Pop of the last beat returns the FSM to IDLE.
- **Ordering and credits**
  - Beats are released strictly in order 0..LINE_BEATS−1.
  - The FIFO never overflows; the credit rule guarantees this, and it is asserted.
- **Other requesters**
  - A one-hot violation on `way_en` is a caller error; selected data is then undefined, but the FSM sequence is unaffected.
  - A new request is never accepted while busy.

## Timing
- **Reset values:** state IDLE, FIFO empty, counters 0, all valids 0, `io_busy` 0, `io_req_ready` 0 while `reset` is high.
- **Latency:**
  - Request accepted in cycle 0.
  - First read issued in cycle 1.
  - First `io_release_valid` in cycle 3.
- **Throughput:** 1 beat/cycle with continuous grant and ready.
  - For LINE_BEATS=16, reads occupy cycles 1–16 and releases cycles 3–18.
  - `io_req_ready` returns in cycle 19.
- **Backpressure:** when `io_release_ready` is low, at most 2 beats are held.
  - Reads stall until a pop frees credit.
  - Release outputs stay stable while valid and not ready.
- **Simultaneous push and pop:** with 2 entries, both occur and occupancy is unchanged.
- **Reset mid-line:** abort immediately, flush the FIFO, return to IDLE; no partial beats are released after reset.

## Structure
- Shared `dcache_pkg`: `LINE_BEATS`, `IDX_BITS`, the state enum (IDLE/READ/DRAIN), and a beat-index width constant.
- One sub-module, `release_buffer`: a 2-entry synchronous FIFO carrying `{beat, data}`, with `count` output, push/pop, and synchronous active-high reset.

## Test plan
1. **Streaming:** idx=5, way_en=4'b0100, grant and ready always high → `io_data_req_bits_addr` steps 0x140, 0x144 … 0x17C in cycles 1–16, with way_en=4'b0100; release beats 0–15 carry `io_data_resp_2` words in cycles 3–18; `last` is high only on beat 15; `io_req_ready` is high in cycle 19.
2. **Release backpressure:** `io_release_ready` low in cycles 3–10 → at most 2 beats buffered and beat 0 held stable; no read issued while credits=2; all 16 beats are delivered in order, none dropped or duplicated.
3. **Grant loss:** `io_data_req_ready` low in cycles 4–6 → the address for beat 3 is held and re-issued in cycle 7; no FIFO push in cycles 5–7.
4. **Way select:** way_en=4'b0001, with resp_0=0xAAAA0000+beat and other ways 0xFFFFFFFF → release data equals 0xAAAA0000+beat for every beat.
5. **Reset mid-line:** assert `reset` for 1 cycle after beat 6 is released → `io_release_valid`=0 and `io_busy`=0 the next cycle; `io_req_ready`=1 once reset is low; a new request restarts at beat 0.
6. **Busy blocking:** `io_req_valid` held high during a writeback → no second accept until the cycle after `last` pops.
